// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and memory-side signals for mem_arbiter.
// slave is the arbiter's view; master is the CPU/memory environment's view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) ();

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_done, d_rdata, d_done, mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_done, d_rdata, d_done, mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported fixed-latency memory, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise data always beats fetch.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LAT    = 4   // legal 2..15, mem_en cycle counts as cycle 1
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
    typedef enum logic [1:0] {OwnNone, OwnInstr, OwnData} owner_e;

    localparam logic [3:0] CntLoad = 4'(LAT - 1);

    state_e            stateQ, stateD;
    owner_e            ownerQ, ownerD;
    logic [3:0]        cntQ, cntD;
    logic              memEnQ, memEnD;
    logic              memWrQ, memWrD;
    logic [ADDR_W-1:0] memAddrQ, memAddrD;
    logic [DATA_W-1:0] memWdataQ, memWdataD;
    logic [DATA_W-1:0] iRdataQ, iRdataD;
    logic [DATA_W-1:0] dRdataQ, dRdataD;
    logic              iDoneQ, iDoneD;
    logic              dDoneQ, dDoneD;

    logic anyReq;
    logic pickData;

    assign anyReq = bus.i_req | bus.d_req;

`ifdef MEM_ARB_RR_EN
    // 1 = data port won the most recent grant; reset favours data on the first tie.
    logic lastDataQ, lastDataD;

    assign pickData  = bus.d_req & (~bus.i_req | ~lastDataQ);
    assign lastDataD = (stateQ == StIdle && anyReq) ? pickData : lastDataQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastDataQ <= 1'b0;
        end else begin
            lastDataQ <= lastDataD;
        end
    end
`else
    assign pickData = bus.d_req;
`endif

    always_comb begin
        stateD    = stateQ;
        ownerD    = ownerQ;
        cntD      = cntQ;
        memEnD    = 1'b0;
        memWrD    = memWrQ;
        memAddrD  = memAddrQ;
        memWdataD = memWdataQ;
        iRdataD   = iRdataQ;
        dRdataD   = dRdataQ;
        iDoneD    = 1'b0;
        dDoneD    = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (anyReq) begin
                    stateD = StIssue;
                    memEnD = 1'b1;
                    cntD   = CntLoad;
                    if (pickData) begin
                        ownerD    = OwnData;
                        memWrD    = bus.d_wr;
                        memAddrD  = bus.d_addr;
                        memWdataD = bus.d_wdata;
                    end else begin
                        ownerD   = OwnInstr;
                        memWrD   = 1'b0;
                        memAddrD = bus.i_addr;
                    end
                end
            end
            StIssue: begin
                stateD = StWait;
            end
            StWait: begin
                if (cntQ == 4'd1) begin
                    // This edge closes transaction cycle LAT, where mem_rdata is valid.
                    stateD = StDone;
                    cntD   = 4'd0;
                    if (ownerQ == OwnData) begin
                        dDoneD = 1'b1;
                        if (!memWrQ) begin
                            dRdataD = bus.mem_rdata;
                        end
                    end else begin
                        iDoneD  = 1'b1;
                        iRdataD = bus.mem_rdata;
                    end
                end else begin
                    cntD = cntQ - 4'd1;
                end
            end
            StDone: begin
                stateD = StIdle;
                ownerD = OwnNone;
                memWrD = 1'b0;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= StIdle;
            ownerQ    <= OwnNone;
            cntQ      <= 4'd0;
            memEnQ    <= 1'b0;
            memWrQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            iRdataQ   <= '0;
            dRdataQ   <= '0;
            iDoneQ    <= 1'b0;
            dDoneQ    <= 1'b0;
        end else begin
            stateQ    <= stateD;
            ownerQ    <= ownerD;
            cntQ      <= cntD;
            memEnQ    <= memEnD;
            memWrQ    <= memWrD;
            memAddrQ  <= memAddrD;
            memWdataQ <= memWdataD;
            iRdataQ   <= iRdataD;
            dRdataQ   <= dRdataD;
            iDoneQ    <= iDoneD;
            dDoneQ    <= dDoneD;
        end
    end

    assign bus.mem_en    = memEnQ;
    assign bus.mem_wr    = memWrQ;
    assign bus.mem_addr  = memAddrQ;
    assign bus.mem_wdata = memWdataQ;
    assign bus.i_rdata   = iRdataQ;
    assign bus.i_done    = iDoneQ;
    assign bus.d_rdata   = dRdataQ;
    assign bus.d_done    = dDoneQ;
    assign bus.busy      = (stateQ != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LAT=4 instance and a LAT=2 instance, each with a
// memory model that drives valid read data only in transaction cycle LAT.
module tb_mem_arbiter;

    localparam int unsigned Lat  = 4;
    localparam int unsigned Lat2 = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LAT(Lat)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LAT(Lat2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Memory models: phase tracks the transaction cycle number after mem_en.
    logic [15:0] memA [256];
    logic [15:0] memB [256];
    logic [3:0]  phA = 4'd0;
    logic [3:0]  phB = 4'd0;

    always @(posedge clk) begin
        if (bus.mem_en) phA <= 4'd2;
        else if (phA == 4'(Lat)) phA <= 4'd0;
        else if (phA != 4'd0) phA <= phA + 4'd1;
    end

    always @(posedge clk) begin
        if (bus2.mem_en) phB <= 4'd2;
        else if (phB == 4'(Lat2)) phB <= 4'd0;
        else if (phB != 4'd0) phB <= phB + 4'd1;
    end

    assign bus.mem_rdata  = (phA == 4'(Lat))  ? memA[bus.mem_addr[7:0]]  : 16'hDEAD;
    assign bus2.mem_rdata = (phB == 4'(Lat2)) ? memB[bus2.mem_addr[7:0]] : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        memA[8'h40] = 16'hA5A5;
        memA[8'h10] = 16'h1111;
        memA[8'h20] = 16'h2222;
        memA[8'h30] = 16'h3333;
        memA[8'h50] = 16'h5555;
        memA[8'h60] = 16'h6666;
        memA[8'h70] = 16'h7777;
        memB[8'h80] = 16'h8080;
        memB[8'h81] = 16'h8181;
        memB[8'h82] = 16'h8282;

        bus.i_req = 1'b0;  bus.i_addr = '0;
        bus.d_req = 1'b0;  bus.d_wr = 1'b0;  bus.d_addr = '0;  bus.d_wdata = '0;
        bus2.i_req = 1'b0; bus2.i_addr = '0;
        bus2.d_req = 1'b0; bus2.d_wr = 1'b0; bus2.d_addr = '0; bus2.d_wdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_i_done", bus.i_done, 0);
        chk("rst_d_done", bus.d_done, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_i_rdata", bus.i_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single fetch read
        bus.i_addr = 16'h0040;
        bus.i_req  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("t1_mem_en", bus.mem_en, c == 1);
            chk("t1_busy", bus.busy, c >= 1 && c <= 5);
            chk("t1_i_done", bus.i_done, c == 5);
            chk("t1_d_done", bus.d_done, 0);
            if (c == 1) begin
                chk("t1_mem_addr", bus.mem_addr, 16'h0040);
                chk("t1_mem_wr", bus.mem_wr, 0);
            end
            if (c == 5) begin
                chk("t1_i_rdata", bus.i_rdata, 16'hA5A5);
                bus.i_req = 1'b0;
            end
        end

        // Data write
        bus.d_wr = 1'b1; bus.d_addr = 16'h1000; bus.d_wdata = 16'h1234; bus.d_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("t2_mem_en", bus.mem_en, c == 1);
            chk("t2_d_done", bus.d_done, c == 5);
            chk("t2_i_done", bus.i_done, 0);
            chk("t2_d_rdata", bus.d_rdata, 16'h0000);
            chk("t2_i_rdata", bus.i_rdata, 16'hA5A5);
            if (c <= 5) begin
                chk("t2_mem_wr", bus.mem_wr, 1);
                chk("t2_mem_addr", bus.mem_addr, 16'h1000);
                chk("t2_mem_wdata", bus.mem_wdata, 16'h1234);
            end
            if (c == 5) begin
                bus.d_req = 1'b0;
                bus.d_wr  = 1'b0;
            end
        end

        // Reset in cycle 3 of a fetch
        bus.i_addr = 16'h0050;
        bus.i_req  = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("t3_mem_en", bus.mem_en, c == 1);
            chk("t3_busy", bus.busy, 1);
        end
        rst_n     = 1'b0;
        bus.i_req = 1'b0;
        #1;
        chk("t3_rst_busy", bus.busy, 0);
        chk("t3_rst_mem_en", bus.mem_en, 0);
        chk("t3_rst_mem_addr", bus.mem_addr, 0);
        chk("t3_rst_mem_wdata", bus.mem_wdata, 0);
        chk("t3_rst_mem_wr", bus.mem_wr, 0);
        chk("t3_rst_i_rdata", bus.i_rdata, 0);
        chk("t3_rst_d_rdata", bus.d_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("t3_post_i_done", bus.i_done, 0);
            chk("t3_post_d_done", bus.d_done, 0);
            chk("t3_post_busy", bus.busy, 0);
            chk("t3_post_mem_en", bus.mem_en, 0);
        end

        // Contention: first tie to data, second tie (d_req kept with new address) by mode
        bus.d_addr = 16'h0010; bus.d_req = 1'b1;
        bus.i_addr = 16'h0020; bus.i_req = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            chk("t4_mem_en", bus.mem_en, c == 1 || c == 7 || c == 13);
            chk("t4_busy", bus.busy, !(c == 6 || c == 12 || c == 18));
            chk("t4_i_done", bus.i_done, c == (RrEn ? 11 : 17));
            chk("t4_d_done", bus.d_done, c == 5 || c == (RrEn ? 17 : 11));
            if (c == 1) chk("t4_addr1", bus.mem_addr, 16'h0010);
            if (c == 7) chk("t4_addr2", bus.mem_addr, RrEn ? 16'h0020 : 16'h0030);
            if (c == 13) chk("t4_addr3", bus.mem_addr, RrEn ? 16'h0030 : 16'h0020);
            if (c == 5) begin
                chk("t4_d_rdata1", bus.d_rdata, 16'h1111);
                bus.d_addr = 16'h0030;
            end else begin
                if (bus.d_done) bus.d_req = 1'b0;
            end
            if (bus.i_done) bus.i_req = 1'b0;
        end
        chk("t4_i_rdata", bus.i_rdata, 16'h2222);
        chk("t4_d_rdata2", bus.d_rdata, 16'h3333);

        // Fetch request raised while a data read is in WAIT
        bus.d_addr = 16'h0060; bus.d_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("t5_mem_en", bus.mem_en, c == 1 || c == 7);
            chk("t5_d_done", bus.d_done, c == 5);
            chk("t5_i_done", bus.i_done, c == 11);
            if (c <= 5) chk("t5_mem_addr_d", bus.mem_addr, 16'h0060);
            if (c >= 7 && c <= 11) chk("t5_mem_addr_i", bus.mem_addr, 16'h0070);
            if (c == 3) begin
                bus.i_addr = 16'h0070;
                bus.i_req  = 1'b1;
            end
            if (c == 5) begin
                chk("t5_d_rdata", bus.d_rdata, 16'h6666);
                bus.d_req = 1'b0;
            end
            if (c == 11) begin
                chk("t5_i_rdata", bus.i_rdata, 16'h7777);
                bus.i_req = 1'b0;
            end
        end

        // LAT=2 instance: back-to-back fetches with i_req held
        bus2.i_addr = 16'h0080;
        bus2.i_req  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("t6_mem_en", bus2.mem_en, (c % 4) == 1);
            chk("t6_i_done", bus2.i_done, (c % 4) == 3);
            chk("t6_busy", bus2.busy, (c % 4) != 0);
            if ((c % 4) == 3) begin
                chk("t6_i_rdata", bus2.i_rdata, 16'h8080 + 16'((c / 4) * 16'h0101));
                if (c == 11) bus2.i_req = 1'b0;
                else bus2.i_addr = bus2.i_addr + 16'h0001;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
